// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: shift-subtract divide, shift-add multiply.
// One bit per cycle on operand magnitudes, sign fix-up on entry to DONE.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               op_i,
    input  logic               sign_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dbz_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DBZ, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic               op_q, neg_q, neg_r, dbz_q;
    logic [WIDTH-1:0]   b_q, hi_q, lo_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] res_q;

    logic               accept, last, neg1, neg2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     diff, sum;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod, fin;

    assign accept = (state == IDLE) && start_i && !annul_i;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign neg1   = sign_i & opdata1_i[WIDTH-1];
    assign neg2   = sign_i & opdata2_i[WIDTH-1];
    assign mag1   = neg1 ? -opdata1_i : opdata1_i;
    assign mag2   = neg2 ? -opdata2_i : opdata2_i;

    // hi/lo hold remainder/quotient for divide, upper/lower product for multiply
    assign diff = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    always_comb begin
        hi_nxt = '0;
        lo_nxt = '0;
        fin    = '0;
        if (op_q) begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
            prod   = {hi_nxt, lo_nxt};
            fin    = neg_q ? -prod : prod;
        end else begin
            prod   = '0;
            hi_nxt = diff[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                 : diff[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
            fin    = {neg_r ? -hi_nxt : hi_nxt, neg_q ? -lo_nxt : lo_nxt};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)
                      state_nxt = (!op_i && opdata2_i == '0) ? DBZ : BUSY;
            DBZ:  state_nxt = DONE;
            BUSY: if (annul_i)   state_nxt = IDLE;
                  else if (last) state_nxt = DONE;
            DONE: if (!start_i)  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q  <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz_q <= 1'b0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else if (accept) begin
            op_q  <= op_i;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            dbz_q <= 1'b0;
            b_q   <= op_i ? mag1 : mag2;
            lo_q  <= op_i ? mag2 : mag1;
            hi_q  <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else if (state == DBZ) begin
            dbz_q <= 1'b1;
            res_q <= '0;
        end else if (state == BUSY) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= cnt + CW'(1);
            if (last) res_q <= fin;
        end
    end

    assign ready_o  = (state == DONE);
    assign busy_o   = (state == DBZ) || (state == BUSY);
    assign dbz_o    = ready_o & dbz_q;
    assign result_o = ready_o ? res_q : '0;
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Expected results come from plain integer arithmetic in a reference model.
module tb_muldiv_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, op, sgn, annul;
    logic [31:0] a, b;
    logic [63:0] result;
    logic        ready, busy, dbz;

    logic        start8, op8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;
    logic        ready8, busy8, dbz8;

    int n_chk = 0;
    int n_fail = 0;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .sign_i(sgn),
        .opdata1_i(a), .opdata2_i(b), .annul_i(annul),
        .result_o(result), .ready_o(ready), .busy_o(busy), .dbz_o(dbz)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .sign_i(sgn8),
        .opdata1_i(a8), .opdata2_i(b8), .annul_i(1'b0),
        .result_o(result8), .ready_o(ready8), .busy_o(busy8), .dbz_o(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // returns {dbz, result} from integer arithmetic at width w (w <= 32)
    function automatic logic [64:0] model(input bit mop, input bit msg,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int w);
        logic [63:0] m, ax, bx, p, q, r;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        ax = {32'd0, x} & m;
        bx = {32'd0, y} & m;
        sa = longint'(ax);
        sb = longint'(bx);
        if (msg && ax[w-1]) sa = sa - (longint'(1) << w);
        if (msg && bx[w-1]) sb = sb - (longint'(1) << w);
        if (mop) begin
            p = 64'(sa * sb);
            if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
            return {1'b0, p};
        end
        if (bx == 0) return {1'b1, 64'd0};
        if (msg) begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end else begin
            q = ax / bx;
            r = ax % bx;
        end
        return {1'b0, ((r & m) << w) | (q & m)};
    endfunction

    task automatic run32(input bit mop, input bit msg, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] er,
                         input bit ed, input int hold);
        int n = 0;
        int nb = 0;
        bit got = 0;
        @(negedge clk);
        start = 1; op = mop; sgn = msg; a = x; b = y; annul = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (ready) got = 1;
            else begin
                op = 1'($urandom); sgn = 1'($urandom);
                a = $urandom; b = $urandom;
            end
        end
        if (!got) begin
            check("timeout", 64'd0, 64'd1);
            start = 0;
            return;
        end
        check("latency", 64'(n), ed ? 64'd2 : 64'd33);
        check("busy_cycles", 64'(nb), ed ? 64'd1 : 64'd32);
        check("result", result, er);
        check("dbz", 64'(dbz), 64'(ed));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", result, er);
            check("hold_ready", 64'(ready), 64'd1);
        end
        start = 0;
        @(negedge clk);
        check("clr_ready", 64'(ready), 64'd0);
        check("clr_result", result, 64'd0);
    endtask

    task automatic run8(input bit mop, input bit msg, input logic [7:0] x,
                        input logic [7:0] y);
        logic [64:0] e;
        int n = 0;
        e = model(mop, msg, {24'd0, x}, {24'd0, y}, 8);
        @(negedge clk);
        start8 = 1; op8 = mop; sgn8 = msg; a8 = x; b8 = y;
        while (!ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", 64'(n), e[64] ? 64'd2 : 64'd9);
        check("w8_result", {48'd0, result8}, e[63:0]);
        check("w8_dbz", 64'(dbz8), 64'(e[64]));
        start8 = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [64:0] e;
        logic [31:0] x, y;
        bit mop, msg;
        int quiet;
        rst = 0; start = 0; op = 0; sgn = 0; a = 0; b = 0; annul = 0;
        start8 = 0; op8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        check("reset_out", {result[62:0], ready}, 64'd0);
        check("reset_flags", {62'd0, busy, dbz}, 64'd0);
        check("reset_w8", {45'd0, result8, ready8, busy8, dbz8}, 64'd0);
        rst = 1;

        run32(0, 0, 100, 7, 64'h00000002_0000000E, 0, 3);
        run32(0, 1, -32'sd7, 2, 64'hFFFFFFFF_FFFFFFFD, 0, 0);
        run32(0, 1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 0);
        run32(0, 0, 5, 0, 64'd0, 1, 1);
        run32(0, 1, 5, 0, 64'd0, 1, 0);
        run32(1, 1, -32'sd3, 5, 64'hFFFFFFFF_FFFFFFF1, 0, 0);
        run32(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 0);

        // abort mid-operation, then reissue
        @(negedge clk);
        start = 1; op = 0; sgn = 0; a = 1000; b = 3;
        repeat (10) @(negedge clk);
        annul = 1; start = 0;
        @(negedge clk);
        check("annul_busy", 64'(busy), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        annul = 0;
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) quiet++;
        end
        check("annul_no_ready", 64'(quiet), 64'd0);
        run32(0, 0, 9, 3, 64'h00000000_00000003, 0, 0);

        // reset mid-operation
        @(negedge clk);
        start = 1; op = 1; sgn = 0; a = 123; b = 456;
        repeat (6) @(negedge clk);
        rst = 0; start = 0;
        @(negedge clk);
        rst = 1;
        check("rst_mid_res", result, 64'd0);
        check("rst_mid_flags", {61'd0, ready, busy, dbz}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            mop = 1'($urandom);
            msg = 1'($urandom);
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 0;
                1:       y = $urandom_range(1, 15);
                2:       y = -$urandom_range(1, 15);
                default: y = $urandom;
            endcase
            e = model(mop, msg, x, y, 32);
            run32(mop, msg, x, y, e[63:0], e[64], 0);
        end

        run8(0, 0, 100, 7);
        check("w8_vector", {48'd0, result8}, 64'h0);
        run8(0, 1, 8'h80, 8'hFF);
        run8(1, 1, 8'hFD, 8'h05);
        run8(0, 0, 8'h11, 8'h00);
        for (int i = 0; i < 20; i++)
            run8(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
